// File: rtl/result_checker.sv
// result_checker: snoops a write bus, compares TEST_PORT writes against an expected ROM and reports the outcome
module result_checker #(
   parameter int                ADDR_W    = 30,
   parameter int                DATA_W    = 32,
   parameter int                IDX_W     = 12,
   parameter int                ERR_W     = 8,
   parameter int                DUR_W     = 16,
   parameter logic [ADDR_W-1:0] TEST_PORT = 30'h3FF,
   parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h168,
   parameter logic [DATA_W-1:0] END_SYM   = 32'hD5D,
   parameter int                CHECK_NUM = 161,
   parameter logic [DUR_W-1:0]  TIMEOUT   = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              wen,
   output logic [IDX_W-1:0]  exp_idx,
   input  logic [DATA_W-1:0] exp_data,
   output logic [ERR_W-1:0]  error_num,
   output logic [DUR_W-1:0]  duration,
   output logic              finish,
   output logic              pass,
   output logic              timeout,
   output logic              early_end,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_data,
   output logic              first_err_vld
);
   localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, REPORT = 2'd2;
   localparam int PW = ERR_W + IDX_W;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [DUR_W-1:0] DUR_MAX = '1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(CHECK_NUM - 1);
   logic [1:0] state;
   logic held, hit, mism, last, early, tmo;
   logic [ERR_W-1:0] err_m, err_n;
   logic [PW-1:0] pen_sum;
   // accept one write per wen pulse and derive the next error count, mismatch applied before the early-end penalty
   always_comb begin
      hit     = wen && !held && addr == TEST_PORT;
      mism    = hit && data != exp_data;
      last    = hit && exp_idx == LAST;
      early   = hit && data == END_SYM && exp_idx < LAST;
      tmo     = duration == TIMEOUT - 1'b1 && !last && !early;
      err_m   = (mism && error_num != ERR_MAX) ? error_num + 1'b1 : error_num;
      pen_sum = PW'(err_m) + PW'(LAST - exp_idx);
      err_n   = !early ? err_m : (pen_sum > PW'(ERR_MAX)) ? ERR_MAX : pen_sum[ERR_W-1:0];
   end
   // remembers last cycle's wen so a stalled write is seen only once
   always_ff @(posedge clk or negedge rst)
      if (!rst) held <= 1'b0;
      else held <= wen;
   // IDLE waits for BEGIN_SYM, CHECK scores writes and watches the clock, REPORT freezes everything
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         error_num      <= ERR_MAX;
         duration       <= '0;
         exp_idx        <= '0;
         finish         <= 1'b0;
         timeout        <= 1'b0;
         early_end      <= 1'b0;
         first_err_idx  <= '0;
         first_err_data <= '0;
         first_err_vld  <= 1'b0;
      end else if (state == IDLE) begin
         if (hit && data == BEGIN_SYM) begin
            state     <= CHECK;
            error_num <= '0;
            duration  <= '0;
            exp_idx   <= '0;
         end
      end else if (state == CHECK) begin
         duration  <= (duration == DUR_MAX) ? duration : duration + 1'b1;
         error_num <= err_n;
         if (hit) exp_idx <= exp_idx + 1'b1;
         if (mism && !first_err_vld) begin
            first_err_idx  <= exp_idx;
            first_err_data <= data;
            first_err_vld  <= 1'b1;
         end
         if (last || early) begin
            state     <= REPORT;
            finish    <= 1'b1;
            early_end <= early;
         end else if (tmo) begin
            state   <= REPORT;
            finish  <= 1'b1;
            timeout <= 1'b1;
         end
      end
   end
   assign pass = finish && error_num == '0 && !timeout && !early_end;
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: directed and randomized runs of result_checker against a queue-based reference model
module tb_result_checker;
   localparam logic [15:0] TO   = 16'h0C00;
   localparam logic [29:0] TP   = 30'h3FF;
   localparam logic [31:0] BEG  = 32'h168;
   localparam logic [31:0] ENDS = 32'hD5D;
   localparam int          N    = 161;
   logic clk = 1'b0, rst = 1'b0, wen = 1'b0;
   logic [29:0] addr = '0;
   logic [31:0] data = '0;
   logic [11:0] exp_idx, first_err_idx;
   logic [31:0] exp_data, first_err_data;
   logic [7:0]  error_num;
   logic [15:0] duration;
   logic finish, pass, timeout, early_end, first_err_vld;
   logic [31:0] rom [0:255];
   int checks = 0, failures = 0;
   longint t_hit, t_begin;
   int dur_t1;
   result_checker #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .exp_idx(exp_idx), .exp_data(exp_data), .error_num(error_num), .duration(duration),
      .finish(finish), .pass(pass), .timeout(timeout), .early_end(early_end),
      .first_err_idx(first_err_idx), .first_err_data(first_err_data), .first_err_vld(first_err_vld)
   );
   always #5 clk = ~clk;
   assign exp_data = rom[exp_idx[7:0]];
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic wr(input logic [29:0] a, input logic [31:0] d, input int hold);
      addr = a; data = d; wen = 1'b1;
      @(posedge clk);
      t_hit = $time;
      repeat (hold - 1) @(posedge clk);
      #1 wen = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      #1 rst = 1'b0; wen = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
   endtask
   task automatic check_idle(input string tag);
      chk({tag, "_idx"}, 64'(exp_idx), 64'd0);
      chk({tag, "_err"}, 64'(error_num), 64'hFF);
      chk({tag, "_dur"}, 64'(duration), 64'd0);
      chk({tag, "_fin"}, 64'(finish), 64'd0);
      chk({tag, "_vld"}, 64'(first_err_vld), 64'd0);
   endtask
   // reference: score the sequence of accepted writes straight from the rules
   function automatic void model(input logic [31:0] s[$], output int err, output int first, output bit early);
      err = 0; first = -1; early = 0;
      foreach (s[i]) begin
         if (s[i] != rom[i]) begin
            err++;
            if (first < 0) first = i;
         end
         if (i < N - 1 && s[i] == ENDS) begin
            early = 1;
            err += N - 1 - i;
         end
      end
      if (err > 255) err = 255;
   endfunction
   task automatic run(input string tag, input int hlo, input int hhi, input int end_at,
                      input int c1, input int c2, input int noise_pct, input int abort_at);
      logic [31:0] sent [$];
      logic [31:0] d;
      logic [29:0] na;
      int err, first, hold;
      bit early;
      do_reset();
      wr(TP, BEG, 1);
      t_begin = t_hit;
      for (int i = 0; i < N; i++) begin
         if (i == abort_at) begin
            do_reset();
            check_idle({tag, "_abort"});
            return;
         end
         if ($urandom_range(99) < noise_pct) begin
            na = 30'($urandom);
            if (na == TP) na = TP ^ 30'h1;
            wr(na, $urandom, 1);
         end
         d = (i == end_at) ? ENDS : rom[i] + ((i == c1 || i == c2) ? 32'd1 : 32'd0);
         if (i == N - 1 || i == end_at) chk({tag, "_prefin"}, 64'(finish), 64'd0);
         hold = $urandom_range(hhi, hlo);
         wr(TP, d, hold);
         sent.push_back(d);
         if (i == end_at) break;
      end
      model(sent, err, first, early);
      chk({tag, "_fin"}, 64'(finish), 64'd1);
      chk({tag, "_idx"}, 64'(exp_idx), 64'(sent.size()));
      chk({tag, "_err"}, 64'(error_num), 64'(err));
      chk({tag, "_early"}, 64'(early_end), 64'(early));
      chk({tag, "_tmo"}, 64'(timeout), 64'd0);
      chk({tag, "_pass"}, 64'(pass), 64'(err == 0 && !early));
      chk({tag, "_vld"}, 64'(first_err_vld), 64'(first >= 0));
      if (first >= 0) begin
         chk({tag, "_fidx"}, 64'(first_err_idx), 64'(first));
         chk({tag, "_fdat"}, 64'(first_err_data), 64'(sent[first]));
      end
      chk({tag, "_dur"}, 64'(duration), 64'((t_hit - t_begin) / 10));
      d = duration;
      wr(TP, BEG, 1);
      wr(TP, rom[0] + 32'd1, 2);
      chk({tag, "_frz_idx"}, 64'(exp_idx), 64'(sent.size()));
      chk({tag, "_frz_dur"}, 64'(duration), 64'(d));
      chk({tag, "_frz_err"}, 64'(error_num), 64'(err));
   endtask
   initial begin
      bit seen;
      for (int i = 0; i < 256; i++) begin
         rom[i] = $urandom;
         while (rom[i] == ENDS || rom[i] + 32'd1 == ENDS) rom[i] = $urandom;
      end
      rom[N - 1] = ENDS;
      do_reset();
      check_idle("rst");
      wr(TP, rom[0], 1);
      wr(TP + 30'h1, BEG, 1);
      check_idle("idle_ign");
      run("t1", 1, 1, -1, -1, -1, 0, -1);
      dur_t1 = duration;
      run("t2", 3, 3, -1, -1, -1, 0, -1);
      chk("t2_longer", 64'(int'(duration) > dur_t1), 64'd1);
      run("t3", 1, 1, -1, 5, 90, 0, -1);
      chk("t3_fdat_rom", 64'(first_err_data), 64'(rom[5] + 32'd1));
      run("t4", 1, 1, 150, -1, -1, 0, -1);
      chk("t4_err11", 64'(error_num), 64'd11);
      do_reset();
      wr(TP, BEG, 1);
      seen = 0;
      for (int c = 0; c < int'(TO) + 20 && !seen; c++) begin
         @(posedge clk);
         #1 seen = finish;
      end
      chk("t5_fin", 64'(finish), 64'd1);
      chk("t5_tmo", 64'(timeout), 64'd1);
      chk("t5_dur", 64'(duration), 64'(TO));
      chk("t5_pass", 64'(pass), 64'd0);
      chk("t5_err", 64'(error_num), 64'd0);
      chk("t5_idx", 64'(exp_idx), 64'd0);
      run("t6a", 1, 1, -1, 7, -1, 0, 40);
      run("t6", 1, 1, -1, -1, -1, 0, -1);
      chk("t6_dur_t1", 64'(duration), 64'(dur_t1));
      for (int r = 0; r < 4; r++)
         run($sformatf("rnd%0d", r), 1, 3, ($urandom_range(1) == 1) ? int'($urandom_range(N - 2)) : -1,
             int'($urandom_range(N - 1)), int'($urandom_range(N - 1)), 20, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
